// File: rtl/fma_pipe.sv
// fma_pipe: LANES independent binary32 multiply-add lanes in a two-stage
// valid/ready pipeline. Stage 1 multiplies a*b, stage 2 adds c; in_mode is
// applied as sign flips on the product and on c ahead of the add.
// Arithmetic: round-to-nearest-even, subnormal inputs/results flushed to zero,
// NaN results are the canonical quiet NaN. A unit raises its exception when
// it sees an Inf/NaN operand or overflows.
module fma_pipe #(
  parameter int LANES = 4,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_a,
  input  logic [LANES*32-1:0]   in_b,
  input  logic [LANES*32-1:0]   in_c,
  input  logic [1:0]            in_mode,
  input  logic [LANES-1:0]      in_mask,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*32-1:0]   out_result,
  output logic [LANES-1:0]      out_exc,
  output logic [TAG_W-1:0]      out_tag,
  output logic [LANES-1:0]      sticky_exc,
  input  logic                  clr_sticky,
  output logic [15:0]           op_count
);

  localparam int          W    = LANES * 32;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Round a normalized 24-bit significand (RNE) and pack; returns {exc, value}.
  function automatic logic [32:0] fp_pack(input logic sgn, input int ex,
                                          input logic [23:0] sig, input logic g,
                                          input logic st);
    logic [24:0] r;
    int          e;
    logic [32:0] res;
    e = ex;
    r = {1'b0, sig} + {24'd0, g & (st | sig[0])};
    if (r[24]) begin
      r = r >> 1;
      e = e + 1;
    end
    if (e >= 255)    res = {1'b1, sgn, 8'hFF, 23'd0};
    else if (e <= 0) res = {1'b0, sgn, 31'd0};
    else             res = {1'b0, sgn, e[7:0], r[22:0]};
    return res;
  endfunction

  // Single-precision multiply; returns {exc, product}.
  function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] p;
    int          e;
    logic [32:0] res;
    sgn    = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = {1'b1, QNAN};
    else if (a_inf || b_inf)   res = {1'b1, sgn, 8'hFF, 23'd0};
    else if (a_zero || b_zero) res = {1'b0, sgn, 31'd0};
    else if (p[47])            res = fp_pack(sgn, e + 1, p[47:24], p[23], |p[22:0]);
    else                       res = fp_pack(sgn, e, p[46:23], p[22], |p[21:0]);
    return res;
  endfunction

  // Single-precision add; returns {exc, sum}.
  function automatic logic [32:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, st;
    logic [31:0] big, sml;
    logic [26:0] mb, ms;
    logic [27:0] s;
    int          d, e;
    logic [32:0] res;
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != '0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == '0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == '0);
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    res    = '0;
    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) res = {1'b1, QNAN};
    else if (x_inf)             res = {1'b1, x};
    else if (y_inf)             res = {1'b1, y};
    else if (x_zero && y_zero)  res = {1'b0, x[31] & y[31], 31'd0};
    else if (x_zero)            res = {1'b0, y};
    else if (y_zero)            res = {1'b0, x};
    else begin
      if (x[30:0] >= y[30:0]) begin
        big = x;
        sml = y;
      end else begin
        big = y;
        sml = x;
      end
      d  = int'(big[30:23]) - int'(sml[30:23]);
      e  = int'(big[30:23]);
      mb = {1'b1, big[22:0], 3'b000};
      ms = {1'b1, sml[22:0], 3'b000};
      st = 1'b0;
      if (d > 26) begin
        st = 1'b1;
        ms = '0;
      end else begin
        for (int unsigned i = 0; i < 27; i++)
          if (int'(i) < d && ms[i]) st = 1'b1;
        ms = ms >> d;
      end
      ms[0] = ms[0] | st;
      if (big[31] == sml[31]) s = {1'b0, mb} + {1'b0, ms};
      else                    s = {1'b0, mb} - {1'b0, ms};
      if (s == '0) begin
        res = '0;
      end else begin
        if (s[27]) begin
          s = {1'b0, s[27:2], s[1] | s[0]};
          e = e + 1;
        end else begin
          for (int unsigned i = 0; i < 26; i++)
            if (!s[26]) begin
              s = s << 1;
              e = e - 1;
            end
        end
        res = fp_pack(big[31], e, s[26:3], s[2], |s[1:0]);
      end
    end
    return res;
  endfunction

  logic                s1_valid;
  logic [W-1:0]        s1_prod, s1_c;
  logic [LANES-1:0]    s1_mexc, s1_mask;
  logic [TAG_W-1:0]    s1_tag;
  logic                s1_advance, in_fire, out_fire;
  logic [W-1:0]        mul_res, c_flip, add_res;
  logic [LANES-1:0]    mul_exc, add_exc;
  logic [32:0]         mul_tmp, add_tmp;

  assign out_fire   = out_valid && out_ready;
  assign s1_advance = s1_valid && (!out_valid || out_ready);
  assign in_ready   = !rst && (!s1_valid || s1_advance);
  assign in_fire    = in_valid && in_ready;

  // Stage 1 datapath: multiply each lane; mode sign flips are folded into the
  // stored product and c so stage 2 is a plain add.
  always_comb begin
    mul_res = '0;
    mul_exc = '0;
    c_flip  = '0;
    mul_tmp = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      mul_tmp = fp_mul(in_a[32*l +: 32], in_b[32*l +: 32]);
      mul_res[32*l +: 32] = {mul_tmp[31] ^ in_mode[1], mul_tmp[30:0]};
      mul_exc[l]          = mul_tmp[32];
      c_flip[32*l +: 32]  = {in_c[32*l + 31] ^ in_mode[0], in_c[32*l +: 31]};
    end
  end

  // Stage 2 datapath: add, merge exceptions, zero out masked lanes.
  always_comb begin
    add_res = '0;
    add_exc = '0;
    add_tmp = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      add_tmp = fp_add(s1_prod[32*l +: 32], s1_c[32*l +: 32]);
      add_res[32*l +: 32] = s1_mask[l] ? add_tmp[31:0] : 32'h0;
      add_exc[l]          = s1_mask[l] & (add_tmp[32] | s1_mexc[l]);
    end
  end

  // Stage 1 register: fill on acceptance, empty when its contents move on.
  always_ff @(posedge clk) begin
    if (rst)             s1_valid <= 1'b0;
    else if (in_fire)    s1_valid <= 1'b1;
    else if (s1_advance) s1_valid <= 1'b0;
    if (in_fire) begin
      s1_prod <= mul_res;
      s1_c    <= c_flip;
      s1_mexc <= mul_exc;
      s1_mask <= in_mask;
      s1_tag  <= in_tag;
    end
  end

  // Stage 2 / output register: load from stage 1, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_exc    <= '0;
      out_tag    <= '0;
    end else if (s1_advance) begin
      out_valid  <= 1'b1;
      out_result <= add_res;
      out_exc    <= add_exc;
      out_tag    <= s1_tag;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Sticky exceptions: a clear coinciding with a handshake keeps that handshake's flags.
  always_ff @(posedge clk) begin
    if (rst)             sticky_exc <= '0;
    else if (clr_sticky) sticky_exc <= out_fire ? out_exc : '0;
    else if (out_fire)   sticky_exc <= sticky_exc | out_exc;
  end

  // Completed-operation counter, saturating.
  always_ff @(posedge clk) begin
    if (rst)                                    op_count <= '0;
    else if (out_fire && op_count != 16'hFFFF)  op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_fma_pipe.sv
// tb_fma_pipe: directed checks of the fma_pipe pipeline, arithmetic, stalls,
// exception reporting, reset behaviour and counter saturation.
module tb_fma_pipe;
  localparam int LANES = 4;
  localparam int TAG_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [LANES*32-1:0] in_a, in_b, in_c;
  logic [1:0]         in_mode;
  logic [LANES-1:0]   in_mask;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid, out_ready;
  logic [LANES*32-1:0] out_result;
  logic [LANES-1:0]   out_exc;
  logic [TAG_W-1:0]   out_tag;
  logic [LANES-1:0]   sticky_exc;
  logic               clr_sticky;
  logic [15:0]        op_count;

  int errors = 0;
  int checks = 0;

  fma_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_mode(in_mode), .in_mask(in_mask), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exc(out_exc), .out_tag(out_tag),
    .sticky_exc(sticky_exc), .clr_sticky(clr_sticky),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
    in_a[32*l +: 32] = a;
    in_b[32*l +: 32] = b;
    in_c[32*l +: 32] = c;
  endtask

  task automatic clear_lanes();
    in_a = '0;
    in_b = '0;
    in_c = '0;
  endtask

  logic [31:0]      exp4 [4];
  logic [31:0]      exp3 [3];
  logic [1:0]       md;
  logic [TAG_W-1:0] tg;
  int               got;
  logic             accept_now, reached;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_mask = '0; in_tag = '0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    clear_lanes();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_op_count", 128'(op_count), 128'(0));
    check("rst_sticky", 128'(sticky_exc), 128'(0));
    check("rst_out_result", 128'(out_result), 128'(0));
    check("rst_out_tag", 128'(out_tag), 128'(0));
    rst = 1'b0;
    #1 check("in_ready_after_rst", 128'(in_ready), 128'(1));

    // Four modes back-to-back, lane 0: 2*3 with c=1
    exp4[0] = 32'h40E00000; exp4[1] = 32'h40A00000;
    exp4[2] = 32'hC0A00000; exp4[3] = 32'hC0E00000;
    for (int i = 0; i < 7; i++) begin
      if (i >= 2 && i < 6) begin
        tg = 8'h10 + 8'(i - 2);
        check("mode_out_valid", 128'(out_valid), 128'(1));
        check("mode_result", 128'(out_result[31:0]), 128'(exp4[i-2]));
        check("mode_tag", 128'(out_tag), 128'(tg));
        check("mode_exc", 128'(out_exc), 128'(0));
      end else begin
        check("mode_idle_valid", 128'(out_valid), 128'(0));
      end
      if (i < 4) begin
        md = 2'(i);
        set_lane(0, 32'h40000000, 32'h40400000, 32'h3F800000);
        in_mode = md; in_mask = 4'b0001; in_tag = 8'h10 + 8'(i);
        in_valid = 1'b1;
        #1 check("mode_in_ready", 128'(in_ready), 128'(1));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("mode_op_count", 128'(op_count), 128'(4));

    // Stall: three ops offered while out_ready is low
    exp3[0] = 32'h40E00000; exp3[1] = 32'h40A00000; exp3[2] = 32'hC0A00000;
    out_ready = 1'b0;
    in_mode = 2'b00; in_tag = 8'h21; in_valid = 1'b1;
    @(negedge clk);
    in_mode = 2'b01; in_tag = 8'h22;
    #1 check("stall_in_ready_op2", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_mode = 2'b10; in_tag = 8'h23;
    #1 check("stall_in_ready_low", 128'(in_ready), 128'(0));
    for (int i = 0; i < 5; i++) begin
      check("stall_hold_valid", 128'(out_valid), 128'(1));
      check("stall_hold_tag", 128'(out_tag), 128'(8'h21));
      check("stall_hold_result", 128'(out_result[31:0]), 128'(exp3[0]));
      check("stall_hold_ready", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      #1;
      accept_now = in_valid && in_ready;
      if (out_valid && out_ready) begin
        tg = 8'h21 + 8'(got);
        check("drain_tag", 128'(out_tag), 128'(tg));
        check("drain_result", 128'(out_result[31:0]), 128'(exp3[got]));
        got++;
      end
      @(negedge clk);
      if (accept_now) in_valid = 1'b0;
    end
    check("drain_count", 128'(got), 128'(3));
    check("drain_no_dup", 128'(out_valid), 128'(0));
    check("drain_op_count", 128'(op_count), 128'(7));

    // Exceptions: Inf operand, masked overflow, unmasked overflow
    in_valid = 1'b0;
    clear_lanes();
    set_lane(0, 32'h7F800000, 32'h40000000, 32'h0);
    set_lane(1, 32'h7F000000, 32'h7F000000, 32'h0);
    set_lane(2, 32'h7F000000, 32'h7F000000, 32'h0);
    in_mode = 2'b00; in_mask = 4'b0101; in_tag = 8'h31; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("exc_valid", 128'(out_valid), 128'(1));
    check("exc_flags", 128'(out_exc), 128'(4'b0101));
    check("exc_lane0", 128'(out_result[31:0]), 128'(32'h7F800000));
    check("exc_lane1_masked", 128'(out_result[63:32]), 128'(0));
    check("exc_lane2_ovf", 128'(out_result[95:64]), 128'(32'h7F800000));
    check("exc_lane3_masked", 128'(out_result[127:96]), 128'(0));
    @(negedge clk);
    check("exc_sticky", 128'(sticky_exc), 128'(4'b0101));

    // Clear coinciding with a handshake carrying exc=0010
    clear_lanes();
    set_lane(0, 32'h40000000, 32'h40400000, 32'h3F800000);
    set_lane(1, 32'h7F800000, 32'h3F800000, 32'h0);
    in_mask = 4'b0011; in_tag = 8'h41; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_hs_exc", 128'(out_exc), 128'(4'b0010));
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("clr_hs_sticky", 128'(sticky_exc), 128'(4'b0010));

    // Sticky accumulates across handshakes
    clear_lanes();
    set_lane(0, 32'h7F800000, 32'h40000000, 32'h0);
    set_lane(2, 32'h7F000000, 32'h7F000000, 32'h0);
    in_mask = 4'b0101; in_tag = 8'h51; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("sticky_or", 128'(sticky_exc), 128'(4'b0111));
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    check("sticky_clear_idle", 128'(sticky_exc), 128'(0));

    // Sign flips apply to zero operands too (mode 11)
    clear_lanes();
    set_lane(0, 32'h00000000, 32'h40000000, 32'h00000000);
    set_lane(1, 32'h40000000, 32'h40400000, 32'h3F800000);
    in_mode = 2'b11; in_mask = 4'b0011; in_tag = 8'h61; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("neg_zero_lane0", 128'(out_result[31:0]), 128'(32'h80000000));
    check("neg_lane1", 128'(out_result[63:32]), 128'(32'hC0E00000));
    @(negedge clk);
    check("pre_rst_op_count", 128'(op_count), 128'(11));

    // Reset with two ops in flight
    clear_lanes();
    set_lane(0, 32'h40000000, 32'h40400000, 32'h3F800000);
    in_mode = 2'b00; in_mask = 4'b0001; in_tag = 8'h71; in_valid = 1'b1;
    @(negedge clk);
    in_tag = 8'h72;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1 check("midrst_in_ready_low", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_in_ready_high", 128'(in_ready), 128'(1));
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_valid", 128'(out_valid), 128'(0));
      @(negedge clk);
    end
    check("midrst_op_count", 128'(op_count), 128'(0));

    // Counter saturation: stream until 16'hFFFE, then at least 3 more handshakes
    out_ready = 1'b1; in_valid = 1'b1;
    reached = 1'b0;
    for (int cyc = 0; cyc < 70000; cyc++) begin
      @(negedge clk);
      if (op_count == 16'hFFFE) begin
        reached = 1'b1;
        break;
      end
    end
    check("sat_reached_fffe", 128'(reached), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("sat_first_step", 128'(op_count), 128'(16'hFFFF));
    repeat (4) @(negedge clk);
    check("sat_hold", 128'(op_count), 128'(16'hFFFF));
    check("sat_idle", 128'(out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
